hw21: RTL and testbench
=======================

# hw21

Free-running calendar clock: one `clk` rising edge equals one second. Holds month, day, hour, minute and second as separate binary fields and rolls them over with correct month lengths. February length is selected by the `leap` input. Sits as a leaf timekeeping block whose outputs feed display and alarm logic.

## Interface
- No parameters. Month lengths and field limits are fixed.
- `clk` input 1: system clock; one rising edge = one second tick.
- `rst` input 1: asynchronous, active-low reset. When low, all fields are forced to their reset values immediately.
- `leap` input 1: 1 means February has 29 days; 0 means 28 days.
- `mon` output 4: month, 1..12 (1 = January).
- `day` output 5: day of month, 1..31.
- `hrs` output 5: hour, 0..23.
- `min` output 6: minute, 0..59.
- `sec` output 6: second, 0..59.

## Operation
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: `mon`=1, `day`=1, `hrs`=0, `min`=0, `sec`=0.
- Every clock edge with `rst` high advances the time by one second, as a carry chain:
  - `sec` increments. At 59 it wraps to 0 and carries to `min`.
  - `min` increments only on a carry. At 59 it wraps to 0 and carries to `hrs`.
  - `hrs` increments only on a carry. At 23 it wraps to 0 and carries to `day`.
  - `day` increments only on a carry. At the last day of the month it wraps to 1 and carries to `mon`.
  - `mon` increments only on a carry. At 12 it wraps to 1 (year rollover; no year output).
- Month-length state machine: one state per month, JAN..DEC. The state equals `mon`, and the transition is taken on a day carry.
  - 31 days: 1, 3, 5, 7, 8, 10, 12.
  - 30 days: 4, 6, 9, 11.
  - February: 29 days if `leap`=1, else 28.
- `leap` is sampled only on the edge where February's last-day check is evaluated. Changing `leap` at any other time has no effect.
- Illegal field values (e.g. `mon`=0 or 13..15, `day`=0, `sec`≥60) are unreachable after reset. If present, the next tick forces the offending field to its reset value.
- All fields carry simultaneously on the same edge when they are all at their limits. Example: 12/31 23:59:59 becomes 1/1 00:00:00 in one cycle.

## Timing
- Latency: one cycle from edge to updated outputs. Each carry ripples within the same cycle; there is no multi-cycle carry.
- Reset asserted mid-count clears all outputs asynchronously, without waiting for a clock edge.
- After `rst` deasserts, the first rising edge produces `sec`=1.
- Rollover of a field and its carry into the next field occur on the same edge.
- Period of a full year: 365×86400 ticks, or 366×86400 ticks with `leap`=1 throughout.

## Test plan
- Reset: hold `rst`=0, toggle `clk` → outputs are 1/1 00:00:00. Release `rst` and apply 60 edges → `sec`=0, `min`=1.
- Hour/day carry: run from reset for 86400 edges → `mon`=1, `day`=2, `hrs`=0, `min`=0, `sec`=0.
- Month lengths: preload 4/30 23:59:59 then tick → 5/1 00:00:00. Preload 1/31 23:59:59 then tick → 2/1 00:00:00.
- Leap: preload 2/28 23:59:59 and tick. With `leap`=1 → 2/29 00:00:00, and a further 86400 ticks → 3/1 00:00:00. With `leap`=0 → 3/1 00:00:00 directly.
- Year wrap: preload 11/30 23:59:59 and tick → 12/1 00:00:00. Preload 12/31 23:59:59 and tick → 1/1 00:00:00.
- Async reset mid-count: drop `rst` between clock edges while at 7/15 13:45:30 → outputs are 1/1 00:00:00 before the next edge.

Source files
------------

// File: rtl/hw21.sv
// Calendar clock: one clk edge per second, month/day/hour/minute/second fields
// rolled over as a single-cycle carry chain with per-month day limits.
package hw21_pkg;
  typedef enum logic [3:0] {
    JAN = 4'd1, FEB = 4'd2, MAR = 4'd3, APR = 4'd4,
    MAY = 4'd5, JUN = 4'd6, JUL = 4'd7, AUG = 4'd8,
    SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12
  } month_e;
endpackage

module hw21
  import hw21_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       leap,
  output logic [3:0] mon,
  output logic [4:0] day,
  output logic [4:0] hrs,
  output logic [5:0] min,
  output logic [5:0] sec
);

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HRS_W = 5;
  localparam int unsigned DAY_W = 5;

  month_e             mon_q, mon_d;
  logic [DAY_W-1:0]   day_q, day_d;
  logic [HRS_W-1:0]   hrs_q, hrs_d;
  logic [MIN_W-1:0]   min_q, min_d;
  logic [SEC_W-1:0]   sec_q, sec_d;

  logic               sec_co, min_co, hrs_co, day_co;
  logic               day_last;
  logic [DAY_W-1:0]   day_max;

  // Time registers; mon_q is also the month-length state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mon_q <= JAN;
      day_q <= DAY_W'(1);
      hrs_q <= '0;
      min_q <= '0;
      sec_q <= '0;
    end else begin
      mon_q <= mon_d;
      day_q <= day_d;
      hrs_q <= hrs_d;
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

  // Seconds, minutes, hours: out-of-range values snap back to zero without carrying.
  always_comb begin
    sec_d  = sec_q + SEC_W'(1);
    sec_co = 1'b0;
    if (sec_q >= SEC_W'(60)) begin
      sec_d = '0;
    end else if (sec_q == SEC_W'(59)) begin
      sec_d  = '0;
      sec_co = 1'b1;
    end

    min_d  = min_q;
    min_co = 1'b0;
    if (min_q >= MIN_W'(60)) begin
      min_d = '0;
    end else if (sec_co) begin
      if (min_q == MIN_W'(59)) begin
        min_d  = '0;
        min_co = 1'b1;
      end else begin
        min_d = min_q + MIN_W'(1);
      end
    end

    hrs_d  = hrs_q;
    hrs_co = 1'b0;
    if (hrs_q >= HRS_W'(24)) begin
      hrs_d = '0;
    end else if (min_co) begin
      if (hrs_q == HRS_W'(23)) begin
        hrs_d  = '0;
        hrs_co = 1'b1;
      end else begin
        hrs_d = hrs_q + HRS_W'(1);
      end
    end
  end

  // Month length; leap only matters when February sits on day 28.
  always_comb begin
    day_max  = DAY_W'(31);
    day_last = (day_q == DAY_W'(31));
    case (mon_q)
      APR, JUN, SEP, NOV: begin
        day_max  = DAY_W'(30);
        day_last = (day_q == DAY_W'(30));
      end
      FEB: begin
        day_max  = DAY_W'(29);
        day_last = (day_q == DAY_W'(29)) || ((day_q == DAY_W'(28)) && !leap);
      end
      default: ;
    endcase
  end

  always_comb begin
    day_d  = day_q;
    day_co = 1'b0;
    if ((day_q == '0) || (day_q > day_max)) begin
      day_d = DAY_W'(1);
    end else if (hrs_co) begin
      if (day_last) begin
        day_d  = DAY_W'(1);
        day_co = 1'b1;
      end else begin
        day_d = day_q + DAY_W'(1);
      end
    end
  end

  // Month state machine: advances on a day carry, illegal encodings recover to JAN.
  always_comb begin
    mon_d = mon_q;
    case (mon_q)
      JAN: if (day_co) mon_d = FEB;
      FEB: if (day_co) mon_d = MAR;
      MAR: if (day_co) mon_d = APR;
      APR: if (day_co) mon_d = MAY;
      MAY: if (day_co) mon_d = JUN;
      JUN: if (day_co) mon_d = JUL;
      JUL: if (day_co) mon_d = AUG;
      AUG: if (day_co) mon_d = SEP;
      SEP: if (day_co) mon_d = OCT;
      OCT: if (day_co) mon_d = NOV;
      NOV: if (day_co) mon_d = DEC;
      DEC: if (day_co) mon_d = JAN;
      default: mon_d = JAN;
    endcase
  end

  assign mon = mon_q;
  assign day = day_q;
  assign hrs = hrs_q;
  assign min = min_q;
  assign sec = sec_q;

endmodule

// File: tb/tb_hw21.sv
// Directed bench for hw21: preload-and-tick vector table plus reset and
// long-run sequences.
module tb_hw21;
  import hw21_pkg::*;

  logic       clk;
  logic       rst;
  logic       leap;
  logic [3:0] mon;
  logic [4:0] day;
  logic [4:0] hrs;
  logic [5:0] min;
  logic [5:0] sec;

  int checks;
  int failures;

  hw21 dut (
    .clk  (clk),
    .rst  (rst),
    .leap (leap),
    .mon  (mon),
    .day  (day),
    .hrs  (hrs),
    .min  (min),
    .sec  (sec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] p_mon;
    logic [4:0] p_day;
    logic [4:0] p_hrs;
    logic [5:0] p_min;
    logic [5:0] p_sec;
    logic       lp;
    logic [3:0] e_mon;
    logic [4:0] e_day;
    logic [4:0] e_hrs;
    logic [5:0] e_min;
    logic [5:0] e_sec;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [3:0] em, input logic [4:0] ed,
                       input logic [4:0] eh, input logic [5:0] emi, input logic [5:0] es);
    checks++;
    if ({mon, day, hrs, min, sec} !== {em, ed, eh, emi, es}) begin
      failures++;
      $display("FAIL %s: got %0d/%0d %0d:%0d:%0d required %0d/%0d %0d:%0d:%0d",
               name, mon, day, hrs, min, sec, em, ed, eh, emi, es);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Overwrite the time registers between edges; takes effect before the next edge.
  task automatic preload(input logic [3:0] m, input logic [4:0] d, input logic [4:0] h,
                         input logic [5:0] mi, input logic [5:0] s);
    dut.mon_q <= month_e'(m);
    dut.day_q <= d;
    dut.hrs_q <= h;
    dut.min_q <= mi;
    dut.sec_q <= s;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{4'd4,  5'd30, 5'd23, 6'd59, 6'd59, 1'b0, 4'd5,  5'd1,  5'd0,  6'd0,  6'd0};
    vecs[1]  = '{4'd1,  5'd31, 5'd23, 6'd59, 6'd59, 1'b0, 4'd2,  5'd1,  5'd0,  6'd0,  6'd0};
    vecs[2]  = '{4'd2,  5'd28, 5'd23, 6'd59, 6'd59, 1'b1, 4'd2,  5'd29, 5'd0,  6'd0,  6'd0};
    vecs[3]  = '{4'd2,  5'd28, 5'd23, 6'd59, 6'd59, 1'b0, 4'd3,  5'd1,  5'd0,  6'd0,  6'd0};
    vecs[4]  = '{4'd11, 5'd30, 5'd23, 6'd59, 6'd59, 1'b0, 4'd12, 5'd1,  5'd0,  6'd0,  6'd0};
    vecs[5]  = '{4'd12, 5'd31, 5'd23, 6'd59, 6'd59, 1'b0, 4'd1,  5'd1,  5'd0,  6'd0,  6'd0};
    vecs[6]  = '{4'd6,  5'd30, 5'd23, 6'd59, 6'd59, 1'b1, 4'd7,  5'd1,  5'd0,  6'd0,  6'd0};
    vecs[7]  = '{4'd3,  5'd31, 5'd23, 6'd59, 6'd59, 1'b0, 4'd4,  5'd1,  5'd0,  6'd0,  6'd0};
    vecs[8]  = '{4'd2,  5'd29, 5'd23, 6'd59, 6'd59, 1'b0, 4'd3,  5'd1,  5'd0,  6'd0,  6'd0};
    vecs[9]  = '{4'd9,  5'd15, 5'd10, 6'd20, 6'd30, 1'b0, 4'd9,  5'd15, 5'd10, 6'd20, 6'd31};
    vecs[10] = '{4'd5,  5'd10, 5'd13, 6'd59, 6'd59, 1'b0, 4'd5,  5'd10, 5'd14, 6'd0,  6'd0};
    vecs[11] = '{4'd8,  5'd31, 5'd23, 6'd59, 6'd59, 1'b0, 4'd9,  5'd1,  5'd0,  6'd0,  6'd0};
    vecs[12] = '{4'd0,  5'd5,  5'd3,  6'd4,  6'd5,  1'b0, 4'd1,  5'd5,  5'd3,  6'd4,  6'd6};
    vecs[13] = '{4'd7,  5'd7,  5'd7,  6'd7,  6'd60, 1'b0, 4'd7,  5'd7,  5'd7,  6'd7,  6'd0};
    vecs[14] = '{4'd4,  5'd31, 5'd0,  6'd0,  6'd0,  1'b0, 4'd4,  5'd1,  5'd0,  6'd0,  6'd1};
    vecs[15] = '{4'd2,  5'd28, 5'd23, 6'd59, 6'd58, 1'b1, 4'd2,  5'd28, 5'd23, 6'd59, 6'd59};
    vecs[16] = '{4'd13, 5'd1,  5'd0,  6'd0,  6'd0,  1'b0, 4'd1,  5'd1,  5'd0,  6'd0,  6'd1};

    // Reset held while the clock runs.
    rst  = 1'b0;
    leap = 1'b0;
    repeat (3) tick();
    check("reset_hold", 4'd1, 5'd1, 5'd0, 6'd0, 6'd0);

    rst = 1'b1;
    tick();
    check("first_tick", 4'd1, 5'd1, 5'd0, 6'd0, 6'd1);
    repeat (59) tick();
    check("sixty_ticks", 4'd1, 5'd1, 5'd0, 6'd1, 6'd0);
    repeat (3600) tick();
    check("hour_carry", 4'd1, 5'd1, 5'd1, 6'd1, 6'd0);

    // Table of single-tick transitions from preloaded times.
    for (int i = 0; i < 17; i++) begin
      leap = vecs[i].lp;
      preload(vecs[i].p_mon, vecs[i].p_day, vecs[i].p_hrs, vecs[i].p_min, vecs[i].p_sec);
      tick();
      check($sformatf("vec%0d", i), vecs[i].e_mon, vecs[i].e_day, vecs[i].e_hrs,
            vecs[i].e_min, vecs[i].e_sec);
    end

    // Leap day, then a full day later lands on March 1 even with leap dropped mid-day.
    leap = 1'b1;
    preload(4'd2, 5'd28, 5'd23, 6'd59, 6'd59);
    tick();
    check("leap_day", 4'd2, 5'd29, 5'd0, 6'd0, 6'd0);
    preload(4'd2, 5'd29, 5'd23, 6'd0, 6'd0);
    repeat (1800) tick();
    leap = 1'b0;
    repeat (1800) tick();
    check("leap_day_end", 4'd3, 5'd1, 5'd0, 6'd0, 6'd0);

    // leap toggling away from Feb 28 changes nothing.
    preload(4'd2, 5'd27, 5'd23, 6'd59, 6'd58);
    tick();
    leap = 1'b1;
    tick();
    check("feb27_roll", 4'd2, 5'd28, 5'd0, 6'd0, 6'd0);
    leap = 1'b0;

    // Asynchronous reset between edges.
    preload(4'd7, 5'd15, 5'd13, 6'd45, 6'd29);
    tick();
    check("pre_async", 4'd7, 5'd15, 5'd13, 6'd45, 6'd30);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 4'd1, 5'd1, 5'd0, 6'd0, 6'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_reset_tick", 4'd1, 5'd1, 5'd0, 6'd0, 6'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
